// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the cache/memory refill arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Byte offset width of one line: word-in-line bits plus the 2 byte-in-word bits.
  function automatic int calc_off(input int beats);
    return $clog2(beats) + 2;
  endfunction

  // Beat counter width; a single-beat line still gets a 1-bit (constant 0) counter.
  function automatic int calc_kw(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/burst_beat_ctr.sv
// Beat counter for one line burst: clear on grant, advance per completed beat,
// flags the final beat so the arbiter can leave BURST.
module burst_beat_ctr
  import cache_arb_pkg::*;
#(
  parameter int BEATS = 4,
  localparam int KW = calc_kw(BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [KW-1:0] k_o,
  output logic          last_o
);

  if (BEATS == 1) begin : g_single
    // With one beat per line the counter is a constant and every beat is the last.
    logic unused_s;
    assign unused_s = clk ^ rst ^ clr_i ^ adv_i;
    assign k_o      = '0;
    assign last_o   = 1'b1;
  end else begin : g_multi
    logic [KW-1:0] k_q;
    logic [KW-1:0] k_d;

    // Next count: clear has priority; advancing past BEATS-1 wraps since BEATS is a power of two.
    always_comb begin
      k_d = k_q;
      if (clr_i) begin
        k_d = '0;
      end else if (adv_i) begin
        k_d = k_q + KW'(1);
      end else begin
        k_d = k_q;
      end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        k_q <= '0;
      end else begin
        k_q <= k_d;
      end
    end

    assign k_o    = k_q;
    assign last_o = (k_q == KW'(BEATS - 1));
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter putting I-side refills and D-side refills/write-backs
// onto one main-memory port as BEATS-word bursts, returning assembled lines.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDR_W-1:0]       i_addr,
  output logic [DATA_W*BEATS-1:0] i_line,
  output logic                    i_done,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_W-1:0]       d_addr,
  input  logic [DATA_W*BEATS-1:0] d_wline,
  output logic [DATA_W*BEATS-1:0] d_line,
  output logic                    d_done,
  output logic                    mem_valid,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_ready,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    busy,
  output logic                    owner
);

  localparam int OFF    = calc_off(BEATS);
  localparam int KW     = calc_kw(BEATS);
  localparam int LINE_W = DATA_W * BEATS;
  localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-OFF){1'b1}}, {OFF{1'b0}}};

  arb_state_e          state_q;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   base_q;
  logic [LINE_W-1:0]   wline_q;
  logic                last_grant_q;
  logic [LINE_W-1:0]   i_line_q;
  logic [LINE_W-1:0]   d_line_q;

  logic                grant_s;
  logic                grant_own_s;
  logic                beat_fire_s;
  logic [KW-1:0]       k_s;
  logic                last_beat_s;

  // Arbitration: a lone request wins; on a tie the side not granted last wins.
  always_comb begin
    grant_s     = 1'b0;
    grant_own_s = OWN_I;
    if (state_q == IDLE) begin
      if (i_req && d_req) begin
        grant_s     = 1'b1;
        grant_own_s = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
      end else if (d_req) begin
        grant_s     = 1'b1;
        grant_own_s = OWN_D;
      end else if (i_req) begin
        grant_s     = 1'b1;
        grant_own_s = OWN_I;
      end else begin
        grant_s     = 1'b0;
        grant_own_s = OWN_I;
      end
    end else begin
      grant_s     = 1'b0;
      grant_own_s = OWN_I;
    end
  end

  assign beat_fire_s = (state_q == BURST) && mem_ready;

  burst_beat_ctr #(.BEATS(BEATS)) u_beat_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (grant_s),
    .adv_i  (beat_fire_s),
    .k_o    (k_s),
    .last_o (last_beat_s)
  );

  // Transfer FSM: latch the granted request, run the burst, capture read beats, strobe done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      we_q         <= 1'b0;
      base_q       <= '0;
      wline_q      <= '0;
      last_grant_q <= OWN_I;
      i_line_q     <= '0;
      d_line_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_s) begin
            owner_q <= grant_own_s;
            if (grant_own_s == OWN_D) begin
              we_q    <= d_we;
              base_q  <= d_addr & BASE_MASK;
              wline_q <= d_wline;
            end else begin
              we_q    <= 1'b0;
              base_q  <= i_addr & BASE_MASK;
              wline_q <= '0;
            end
            state_q <= BURST;
          end else begin
            state_q <= IDLE;
          end
        end
        BURST: begin
          if (beat_fire_s) begin
            if (!we_q) begin
              if (owner_q == OWN_I) begin
                i_line_q[k_s*DATA_W +: DATA_W] <= mem_rdata;
              end else begin
                d_line_q[k_s*DATA_W +: DATA_W] <= mem_rdata;
              end
            end
            if (last_beat_s) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          last_grant_q <= owner_q;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory-side outputs decode purely from registered state, so a stalled beat holds them.
  assign mem_valid = (state_q == BURST);
  assign mem_we    = mem_valid && we_q;
  assign mem_addr  = base_q | (ADDR_W'(k_s) << 2);
  assign mem_wdata = wline_q[k_s*DATA_W +: DATA_W];

  assign i_done = (state_q == DONE) && (owner_q == OWN_I);
  assign d_done = (state_q == DONE) && (owner_q == OWN_D);
  assign busy   = (state_q != IDLE);
  assign owner  = owner_q;
  assign i_line = i_line_q;
  assign d_line = d_line_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a simple memory model.
module tb_cache_mem_arbiter;

  logic         clk;
  logic         rst;
  logic         i_req;
  logic [31:0]  i_addr;
  logic [127:0] i_line;
  logic         i_done;
  logic         d_req;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [127:0] d_wline;
  logic [127:0] d_line;
  logic         d_done;
  logic         mem_valid;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic         busy;
  logic         owner;

  logic [31:0]  rd_tag;
  int           errors;
  int           checks;
  int           n;

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BEATS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_line    (i_line),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wline   (d_wline),
    .d_line    (d_line),
    .d_done    (d_done),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data is a per-test tag plus the word index within the line.
  always_comb mem_rdata = rd_tag + {30'b0, mem_addr[3:2]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(i_done || d_done) && cyc < 40);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wline = 128'h0; mem_ready = 1'b1; rd_tag = 32'hA0;
    tick(); tick();

    // Reset values
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_dones", {i_done, d_done}, 2'b00);
    chk("rst_busy_owner", {busy, owner}, 2'b00);
    chk("rst_i_line", i_line, 128'h0);
    chk("rst_d_line", d_line, 128'h0);

    // I-only refill at 0x1234
    rst = 1'b0; i_req = 1'b1; i_addr = 32'h0000_1234;
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("i1_valid", mem_valid, 1'b1);
      chk("i1_addr", mem_addr, 32'h1230 + 32'(4 * b));
      chk("i1_no_done", i_done, 1'b0);
    end
    tick();
    chk("i1_done", {i_done, d_done}, 2'b10);
    chk("i1_line", i_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    i_req = 1'b0;
    tick();
    chk("i1_idle", {busy, i_done}, 2'b00);

    // Tie after reset: D, I, D, I
    rst = 1'b1; tick(); rst = 1'b0;
    rd_tag = 32'hB0; i_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    wait_done(n);
    chk("tie1_lat", n, 5);
    chk("tie1_d", {i_done, d_done, owner}, 3'b011);
    chk("tie1_dline", d_line, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    d_req = 1'b0;
    wait_done(n);
    chk("tie2_lat", n, 6);
    chk("tie2_i", {i_done, d_done, owner}, 3'b100);
    chk("tie2_iline", i_line, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    d_req = 1'b1;
    wait_done(n);
    chk("tie3_d", {i_done, d_done, owner}, 3'b011);
    d_req = 1'b0;
    wait_done(n);
    chk("tie4_i", {i_done, d_done, owner}, 3'b100);
    i_req = 1'b0;
    tick();

    // D write-back of {4,3,2,1} at 0x80
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80;
    d_wline = {32'd4, 32'd3, 32'd2, 32'd1};
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("wb_we", mem_we, 1'b1);
      chk("wb_addr", mem_addr, 32'h80 + 32'(4 * b));
      chk("wb_wdata", mem_wdata, 32'(b + 1));
    end
    tick();
    chk("wb_done", {i_done, d_done}, 2'b01);
    chk("wb_dline_kept", d_line, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    d_req = 1'b0;
    tick();
    chk("wb_done_once", d_done, 1'b0);

    // Backpressure: 3 stall cycles on beat 2 of a write-back
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40;
    d_wline = {32'h44, 32'h33, 32'h22, 32'h11};
    tick(); tick(); tick();
    chk("bp_beat2_addr", mem_addr, 32'h48);
    mem_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("bp_hold", {mem_valid, mem_addr, mem_wdata}, {1'b1, 32'h48, 32'h33});
    end
    mem_ready = 1'b1;
    wait_done(n);
    chk("bp_lat", 3 + 3 + n, 8);
    chk("bp_done", d_done, 1'b1);
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // Reset during beat 1 of a D refill
    rd_tag = 32'hC0; d_addr = 32'h500; d_req = 1'b1;
    tick(); tick();
    chk("rr_beat1", mem_addr, 32'h504);
    rst = 1'b1; d_req = 1'b0;
    tick();
    chk("rr_state", {busy, mem_valid, d_done}, 3'b000);
    chk("rr_dline", d_line, 128'h0);
    chk("rr_addr", mem_addr, 32'h0);
    rst = 1'b0;
    tick();
    chk("rr_no_done", d_done, 1'b0);
    d_req = 1'b1;
    wait_done(n);
    chk("rr_fresh_lat", n, 5);
    chk("rr_fresh_line", d_line, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    d_req = 1'b0;
    tick();

    // I request held through done: second transfer follows
    rd_tag = 32'hD0; i_addr = 32'h2004; i_req = 1'b1;
    wait_done(n);
    chk("hold1_lat", n, 5);
    tick();
    chk("hold_idle", {busy, i_done}, 2'b00);
    tick();
    chk("hold2_grant", {mem_valid, owner, mem_addr}, {1'b1, 1'b0, 32'h2000});
    wait_done(n);
    chk("hold2_lat", n, 4);
    chk("hold2_done", i_done, 1'b1);
    chk("hold2_line", i_line, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    i_req = 1'b0;
    tick();
    chk("hold_end", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the instruction-fetch refill path and the data-cache refill/write-back path onto a single shared main-memory port. It sits between the IMEM/CacheModule1 miss logic and backing memory, serialising line transfers as multi-beat bursts. It returns assembled lines and a one-cycle completion strobe to whichever side owned the burst. Round-robin arbitration prevents either pipeline side from starving the other.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, memory word width; one beat = one word
- BEATS, 4, words per cache line; power of two, ≥1
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  instruction-side refill request (level)
- i_addr  in  ADDR_W  instruction miss address
- i_line  out  DATA_W*BEATS  assembled line; word k at bits [k*DATA_W +: DATA_W]
- i_done  out  1  one-cycle completion strobe, instruction side
- d_req  in  1  data-side request (level)
- d_we  in  1  1 = line write-back, 0 = line refill
- d_addr  in  ADDR_W  data miss/victim address
- d_wline  in  DATA_W*BEATS  write-back line, same packing as i_line
- d_line  out  DATA_W*BEATS  assembled refill line
- d_done  out  1  one-cycle completion strobe, data side
- mem_valid  out  1  beat request to memory
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  beat word address
- mem_wdata  out  DATA_W  write beat data
- mem_ready  in  1  memory accepts or completes the current beat
- mem_rdata  in  DATA_W  read data; valid when mem_valid & mem_ready & ~mem_we
- busy  out  1  state ≠ IDLE
- owner  out  1  0 = I side, 1 = D side; meaningful only while busy

## Operation
- FSM states: IDLE, BURST, DONE.
- IDLE: if exactly one req is high, grant it. If both are high, grant the side not granted last. last_grant resets to I, so D wins the first tie. On a grant, latch owner, we (forced 0 for I side), the line-aligned base address, and wdata; clear beat counter k; go to BURST.
- BURST: mem_valid=1. mem_addr = {base[ADDR_W-1:OFF], k, 2'b00}, where OFF = log2(BEATS)+2. mem_wdata = latched word k.
  - A beat completes when mem_valid & mem_ready. On a read beat, capture mem_rdata into the owner's line word k.
  - Then k increments. The beat with k = BEATS-1 goes to DONE and k wraps to 0.
  - mem_ready low holds all mem_* outputs stable.
- DONE: assert the owner's done. Update last_grant to owner. Go to IDLE.
- Requesters hold req, addr, we and wline stable from assertion until they see done. They must deassert req in the done cycle.
  - A req still high in the following IDLE cycle is treated as a new request.
- i_line and d_line hold their value until the next refill for that side overwrites them beat by beat. The line is valid to consume in the done cycle.
- Requests arriving outside IDLE are ignored until IDLE; no queuing.
- A write-back leaves d_line unchanged.

## Timing
- Reset values: state IDLE, mem_valid 0, mem_we 0, mem_addr 0, mem_wdata 0, i_done 0, d_done 0, busy 0, owner 0, i_line 0, d_line 0, k 0, last_grant I.
- All outputs are registered or decoded from registered state; there is no combinational req→mem path.
- Grant latency: req high at edge t → mem_valid high from cycle t+1.
- With mem_ready tied high, a transfer takes 1 grant + BEATS beats + 1 DONE = BEATS+2 cycles from req to done. The next grant can occur the cycle after DONE.
- Simultaneous req in IDLE: a single grant per the round-robin rule; the loser waits at least one full transfer.
- Reset mid-BURST or mid-DONE: abort immediately to reset values. No done is issued and partial line data is discarded (cleared).
- BEATS=1: k is zero width and is treated as constant 0; BURST lasts one handshake.

## Structure
- Shared package cache_arb_pkg: state enum {IDLE, BURST, DONE}; owner constants OWN_I=0 and OWN_D=1; localparam function computing OFF from BEATS.
- One sub-module, burst_beat_ctr: beat counter with clear, advance, and last-beat flag, parameterised by BEATS.
- Line capture and the arbitration FSM stay in the top module.

## Test plan
- I-only refill: i_addr=0x0000_1234, mem_ready=1, rdata = beat index + 0xA0.
  - mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C.
  - i_done at cycle 6; i_line = {0xA3,0xA2,0xA1,0xA0}.
- D write-back: d_we=1, d_addr=0x80, d_wline={4,3,2,1}.
  - mem_we=1; mem_wdata 1,2,3,4 at 0x80–0x8C.
  - d_done once; d_line unchanged.
- Simultaneous i_req and d_req after reset: D is served first, then I.
  - Repeat the tie: grants alternate D, I, D, I.
- Backpressure: mem_ready low for 3 cycles on beat 2.
  - mem_addr/mem_wdata are held constant for those cycles.
  - Total latency grows by exactly 3 cycles.
- Reset asserted during beat 1 of a D refill: next cycle busy=0, mem_valid=0, d_line=0, and no d_done.
  - A fresh d_req afterwards completes normally.
- req held high through done: a second full transfer to the same address follows, starting in the IDLE cycle after DONE.
